// File: rtl/keyed_capture_guard.sv
// Key-gated slice capture: samples DIN[DW-1:0] every 2^PHASE_W enabled cycles and
// packs DEPTH slices into one frame; wrong keys relock, MAX_FAIL misses latch a lockout.
module keyed_capture_guard #(
  parameter int                IW       = 8,
  parameter int                DW       = 3,
  parameter int                DEPTH    = 4,
  parameter int                PHASE_W  = 2,
  parameter int                KEY_W    = 2,
  parameter logic [KEY_W-1:0]  KEY_VAL  = 2'b01,
  parameter int                MAX_FAIL = 3,
  parameter int                CW       = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENA,
  input  logic                  KEY_LOAD,
  input  logic [KEY_W-1:0]      KEY,
  input  logic [IW-1:0]         DIN,
  output logic [DW*DEPTH-1:0]   DOUT,
  output logic                  DVALID,
  output logic [CW-1:0]         CNT,
  output logic [PHASE_W-1:0]    PHASE,
  output logic                  LOCKED,
  output logic                  LOCKOUT
);

  localparam int AW  = DW * (DEPTH - 1);
  localparam int FW  = DW * DEPTH;
  localparam int SCW = $clog2(DEPTH);
  localparam int FCW = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [SCW-1:0]      slice_cnt_q, slice_cnt_d;
  logic [FCW-1:0]      fail_cnt_q, fail_cnt_d;
  logic [FW-1:0]       dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                locked_q, locked_d;
  logic                lockout_q, lockout_d;

  logic                key_ok;
  logic                key_bad;
  logic [FCW-1:0]      fail_next;
  logic                fail_hit;
  logic [DW-1:0]       slice;

  generate
    if (IW > DW) begin : g_din_hi
      logic unused_din_hi;
      assign unused_din_hi = ^DIN[IW-1:DW];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    slice_cnt_d = slice_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    cnt_d       = cnt_q;

    key_ok    = KEY_LOAD && (KEY == KEY_VAL);
    key_bad   = KEY_LOAD && (KEY != KEY_VAL);
    fail_next = fail_cnt_q + 1'b1;
    fail_hit  = (fail_next == FCW'(MAX_FAIL));
    slice     = DIN[DW-1:0];

    case (state_q)
      ST_LOCKED: begin
        if (key_ok) begin
          state_d     = ST_UNLOCKED;
          fail_cnt_d  = '0;
          phase_d     = '0;
          slice_cnt_d = '0;
          acc_d       = '0;
        end else if (key_bad) begin
          fail_cnt_d = fail_next;
          if (fail_hit) state_d = ST_LOCKOUT;
        end
      end
      ST_UNLOCKED: begin
        // A wrong key wins over a capture on the same edge; the slice is dropped.
        if (key_bad) begin
          state_d     = fail_hit ? ST_LOCKOUT : ST_LOCKED;
          fail_cnt_d  = fail_next;
          phase_d     = '0;
          acc_d       = '0;
          slice_cnt_d = '0;
          dout_d      = '0;
        end else if (ENA) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == '1) begin
            if (slice_cnt_q == SCW'(DEPTH - 1)) begin
              dout_d      = {acc_q, slice};
              dvalid_d    = 1'b1;
              cnt_d       = cnt_q + 1'b1;
              slice_cnt_d = '0;
              acc_d       = '0;
            end else begin
              acc_d       = (acc_q << DW) | AW'(slice);
              slice_cnt_d = slice_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_LOCKOUT: begin
        dout_d  = '0;
        phase_d = '0;
      end
      default: begin
        state_d = ST_LOCKED;
      end
    endcase

    locked_d  = (state_d != ST_UNLOCKED);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_LOCKED;
      phase_q     <= '0;
      acc_q       <= '0;
      slice_cnt_q <= '0;
      fail_cnt_q  <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      cnt_q       <= '0;
      locked_q    <= 1'b1;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      slice_cnt_q <= slice_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      cnt_q       <= cnt_d;
      locked_q    <= locked_d;
      lockout_q   <= lockout_d;
    end
  end

  assign DOUT    = dout_q;
  assign DVALID  = dvalid_q;
  assign CNT     = cnt_q;
  assign PHASE   = phase_q;
  assign LOCKED  = locked_q;
  assign LOCKOUT = lockout_q;

endmodule

// File: doc/keyed_capture_guard.md
# keyed_capture_guard

Parametrised, key-gated slice capture cell for the protection path. After a correct key load it samples a DW-bit slice of the input bus once every 2^PHASE_W enabled cycles and packs DEPTH slices into one output frame with a one-cycle valid strobe. Wrong keys relock the cell and clear its captured data. A configurable number of consecutive failures latches a hard lockout that only reset clears.

## Interface
- IW, 8: input bus width.
- DW, 3: slice width, taken from DIN[DW-1:0]; DW <= IW.
- DEPTH, 4: slices per frame; DEPTH >= 2.
- PHASE_W, 2: phase counter width; capture period is 2^PHASE_W enabled cycles.
- KEY_W, 2: key width.
- KEY_VAL, 2'b01: unlock key.
- MAX_FAIL, 3: consecutive wrong keys that trigger lockout; MAX_FAIL >= 1.
- CW, 4: frame counter width.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: synchronous reset, active-high; highest priority.
- ENA in 1: phase/capture enable.
- KEY_LOAD in 1: single-cycle key strobe.
- KEY in KEY_W: key value, sampled when KEY_LOAD=1.
- DIN in IW: data input.
- DOUT out DW*DEPTH: last completed frame; the first slice sits in the MSBs.
- DVALID out 1: one-cycle pulse on a new frame.
- CNT out CW: completed frames, wraps mod 2^CW.
- PHASE out PHASE_W: current phase.
- LOCKED out 1: high in LOCKED or LOCKOUT.
- LOCKOUT out 1: high in LOCKOUT.

## Operation
- States: LOCKED (reset state), UNLOCKED, LOCKOUT.
- Registered internals:
  - acc, width DW*(DEPTH-1).
  - slice_cnt, 0..DEPTH-1.
  - fail_cnt, 0..MAX_FAIL.
- LOCKED:
  - KEY_LOAD with KEY==KEY_VAL: go to UNLOCKED; clear fail_cnt, phase, slice_cnt and acc.
  - KEY_LOAD with a wrong key: increment fail_cnt. When it reaches MAX_FAIL, go to LOCKOUT.
  - ENA is ignored.
- UNLOCKED with ENA=1 and no wrong KEY_LOAD:
  - PHASE increments mod 2^PHASE_W.
  - If PHASE==2^PHASE_W-1 on that edge, capture DIN[DW-1:0].
    - If slice_cnt<DEPTH-1: acc shifts left by DW with the new slice in the LSBs; slice_cnt increments.
    - If slice_cnt==DEPTH-1: DOUT takes {acc, slice}; DVALID is set for the next cycle; CNT increments; slice_cnt and acc clear.
- UNLOCKED with ENA=0: PHASE, acc and slice_cnt hold.
- UNLOCKED, KEY_LOAD with the correct key: no effect; capture proceeds normally.
- UNLOCKED, KEY_LOAD with a wrong key:
  - Go to LOCKED.
  - Clear phase, acc, slice_cnt and DOUT; any capture on that edge is discarded.
  - Increment fail_cnt. If it reaches MAX_FAIL, go to LOCKOUT instead.
- LOCKOUT:
  - All KEY_LOAD and ENA activity is ignored.
  - DOUT=0, DVALID=0, PHASE=0.
  - CNT holds. Exit is by RST only.
- Width rules:
  - All counters wrap silently.
  - DIN bits above DW-1 are ignored.

## Timing
- Reset values (one RST edge):
  - state LOCKED; LOCKED=1, LOCKOUT=0.
  - DOUT=0, DVALID=0, CNT=0, PHASE=0.
  - acc=0, slice_cnt=0, fail_cnt=0.
- RST mid-frame discards partial slices.
- The unlock takes effect on the KEY_LOAD edge; UNLOCKED holds from the next cycle.
- With ENA held high, the first capture occurs on the 2^PHASE_W-th edge after unlock. DVALID is high in the cycle after the DEPTH-th capture edge.
  - Latency from the unlock edge to the DVALID cycle is DEPTH*2^PHASE_W cycles (16 at defaults).
- DVALID is exactly one cycle wide. DOUT is stable from that cycle until the next frame, relock or reset.
- CNT updates on the same edge as DOUT.
- Simultaneous events: RST > wrong KEY_LOAD > capture.
- A correct KEY_LOAD concurrent with a capture does not block the capture.

## Test plan
- Reset: assert RST for 2 cycles with arbitrary inputs -> DOUT=0, DVALID=0, CNT=0, PHASE=0, LOCKED=1, LOCKOUT=0.
- Basic frame (defaults): KEY_LOAD with KEY=2'b01, then ENA=1. Hold DIN[2:0]=3'b101, 3'b010, 3'b111, 3'b001 for successive 4-cycle windows -> DVALID pulses exactly once, 16 cycles after unlock; DOUT=12'hAB9; CNT=1.
- ENA gapping: same stimulus with ENA alternating 1/0 and each DIN value held for 8 cycles -> DVALID pulses 32 cycles after unlock; DOUT=12'hAB9; PHASE holds while ENA=0.
- Relock mid-frame: after 2 captures, KEY_LOAD with KEY=2'b10 -> LOCKED=1, DOUT=0, PHASE=0. Then unlock and send slices 3'b000, 3'b001, 3'b010, 3'b011 -> DOUT=12'h053 with no stale slices.
- Lockout: three KEY_LOADs with KEY=2'b10 from reset -> LOCKOUT=1 after the third edge. A following KEY=2'b01 load with ENA=1 for 20 cycles -> no DVALID, PHASE=0. RST -> LOCKOUT=0, LOCKED=1.
- Fail-count clear and CNT wrap: two wrong keys, one correct key, then one wrong key -> remains LOCKED with LOCKOUT=0. Then 16 consecutive frames -> CNT wraps to 0, with exactly 16 DVALID pulses.
